game_switch_ctrl: RTL



---
 rtl/game_switch_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/game_switch_ctrl.sv
// rtl/game_switch_ctrl.sv - game select sequencer: debounced reload, frame-aligned core reset, RAM clear handshake
module game_switch_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          RESET_HOLD      = 64,
  parameter int          VBL_TIMEOUT     = 400000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       load_btn,
  input  logic       vblank,
  input  logic       clr_done,
  output logic [3:0] game,
  output logic       sys_rst_n,
  output logic       clr_req,
  output logic       busy,
  output logic       game_changed
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int TW = $clog2(VBL_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(VBL_TIMEOUT - 1);

  localparam logic [3:0] EMS = 4'd0, MARIO = 4'd1, DONKEY_KONG = 4'd2, PACMAN = 4'd3,
                         GALAGA = 4'd4, DEFENDER2 = 4'd5, TENNIS = 4'd6, GOLF = 4'd7,
                         PINBALL = 4'd8;

  typedef enum logic [1:0] {HOLD, CLEAR, RUN, ARM} state_t;

  state_t        state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [TW-1:0] to_cnt, to_next;
  logic [3:0]    game_next;
  logic          srst_next, clr_next, busy_next, chg_next;

  logic [3:0]  sw_meta, sw_sync;
  logic        btn_meta, btn_sync, btn_db, btn_db_d;
  logic [15:0] db_cnt;
  logic        press;

  function automatic logic [3:0] decode(input logic [3:0] s);
    case (s)
      4'b0001: return MARIO;
      4'b0010: return DONKEY_KONG;
      4'b0011: return PACMAN;
      4'b0100: return GALAGA;
      4'b0101: return DEFENDER2;
      4'b0110: return TENNIS;
      4'b0111: return GOLF;
      4'b1000: return PINBALL;
      default: return EMS;
    endcase
  endfunction

  // Debounce timer only runs while the synchronized input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= load_btn;
      btn_sync <= btn_meta;
      btn_db_d <= btn_db;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end
  end

  assign press = btn_db & ~btn_db_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HOLD;
      hold_cnt     <= '0;
      to_cnt       <= '0;
      game         <= EMS;
      sys_rst_n    <= 1'b0;
      clr_req      <= 1'b0;
      busy         <= 1'b1;
      game_changed <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_next;
      to_cnt       <= to_next;
      game         <= game_next;
      sys_rst_n    <= srst_next;
      clr_req      <= clr_next;
      busy         <= busy_next;
      game_changed <= chg_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    to_next    = to_cnt;
    game_next  = game;
    srst_next  = sys_rst_n;
    clr_next   = clr_req;
    chg_next   = 1'b0;
    case (state)
      HOLD: begin
        srst_next = 1'b0;
        hold_next = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          game_next  = decode(sw_sync);
          clr_next   = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        clr_next  = 1'b1;
        srst_next = 1'b0;
        if (clr_done) begin
          clr_next   = 1'b0;
          srst_next  = 1'b1;
          chg_next   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        srst_next = 1'b1;
        if (press) begin
          to_next    = '0;
          state_next = ARM;
        end
      end
      ARM: begin
        // Core keeps running until the frame boundary so the reload is glitch-free on screen.
        srst_next = 1'b1;
        to_next   = to_cnt + 1'b1;
        if (vblank || to_cnt == TO_LAST) begin
          hold_next  = '0;
          srst_next  = 1'b0;
          state_next = HOLD;
        end
      end
      default: state_next = HOLD;
    endcase
    busy_next = (state_next != RUN);
  end

endmodule
